// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code set 2 receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Keyboard acknowledge/status bytes that carry no key event when unprefixed.
    function automatic logic ps2_is_ctrl(input logic [7:0] code);
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus saturating-count glitch filter; pulses fall_o for one
// cycle when the filtered line goes from 1 to 0.
module ps2_line_filter #(
    parameter int unsigned FILTER = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw_i,
    output logic fall_o
);

    localparam int unsigned CntW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER - 1);

    logic [1:0]      sync_q, sync_d;
    logic            level_q, level_d;
    logic            fall_q, fall_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], raw_i};
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = cnt_q;
        // Any sample that agrees with the filtered level restarts the run.
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d   = '0;
            level_d = sync_q[1];
            fall_d  = ~sync_q[1];
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deserialises set-2 frames, folds E0/F0/E1 prefixes and
// publishes toggle-strobed 11-bit key events.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 96000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
    localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);
    localparam logic [WdogW-1:0] WdogMax  = WdogW'(TIMEOUT);
    localparam logic [WdogW-1:0] WdogOne  = WdogW'(1);

    logic             strobe;
    logic [1:0]       data_sync_q;
    logic             data_bit;
    ps2_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             ext_q, ext_d;
    logic             rel_q, rel_d;
    logic [2:0]       skip_q, skip_d;
    logic [WdogW-1:0] wdog_q, wdog_d;
    logic [10:0]      key_q, key_d;
    logic             err_q;
    logic             timeout, start_err, frame_good, frame_bad, err_now;

    ps2_line_filter #(
        .FILTER (FILTER)
    ) u_clk_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .raw_i   (ps2_clk),
        .fall_o  (strobe)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            data_sync_q <= 2'b11;
        end else begin
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    assign data_bit = data_sync_q[1];

    // Frame FSM: state register.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM: next state. A strobe always wins over the watchdog.
    always_comb begin
        state_d = state_q;
        if (strobe) begin
            unique case (state_q)
                StIdle:   if (!data_bit) state_d = StData;
                StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end else if (timeout) begin
            state_d = StIdle;
        end
    end

    // Frame FSM: decoded frame outcomes.
    always_comb begin
        timeout    = (state_q != StIdle) && !strobe && (wdog_q == WdogLast);
        start_err  = strobe && (state_q == StIdle) && data_bit;
        frame_good = strobe && (state_q == StStop) && data_bit && (^{shift_q, par_q});
        frame_bad  = strobe && (state_q == StStop) && !frame_good;
        err_now    = start_err || frame_bad || timeout;
    end

    // Bit capture and watchdog.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        if (strobe) begin
            unique case (state_q)
                StIdle: bit_cnt_d = 3'd0;
                StData: begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                StParity: par_d = data_bit;
                default: ;
            endcase
        end

        // Counts from 1 on the strobe so the abort lands TIMEOUT cycles after it.
        if (state_d == StIdle) begin
            wdog_d = '0;
        end else if (strobe) begin
            wdog_d = WdogOne;
        end else if (wdog_q != WdogMax) begin
            wdog_d = wdog_q + 1'b1;
        end else begin
            wdog_d = wdog_q;
        end
    end

    // Prefix folding and key event publication.
    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        key_d  = key_q;
        if (err_now) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = 3'd0;
        end else if (frame_good) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (shift_q == PS2_PAUSE) begin
                skip_d = PAUSE_SKIP;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end else if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_REL) begin
                rel_d = 1'b1;
            end else if (ext_q || rel_q || !ps2_is_ctrl(shift_q)) begin
                key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            ext_q     <= 1'b0;
            rel_q     <= 1'b0;
            skip_q    <= 3'd0;
            wdog_q    <= '0;
            key_q     <= 11'h000;
            err_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            ext_q     <= ext_d;
            rel_q     <= rel_d;
            skip_q    <= skip_d;
            wdog_q    <= wdog_d;
            key_q     <= key_d;
            err_q     <= err_now;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit and checks events.
module tb_ps2_key_decoder;

    localparam int unsigned FILT = 8;
    localparam int unsigned TMO  = 300;
    localparam int unsigned H    = 20;

    logic        clk_sys  = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int key_chg_cyc = 0;
    int last_fall = 0;
    logic [10:0] key_prev = 11'h000;

    ps2_key_decoder #(
        .FILTER  (FILT),
        .TIMEOUT (TMO)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (frame_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (ps2_key !== key_prev) begin
            key_prev    <= ps2_key;
            key_chg_cyc <= cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            step(12);
            ps2_clk = 1'b0;
            step(3);
            ps2_clk = 1'b1;
            step(12);
        end else begin
            step(H);
        end
        ps2_clk   = 1'b0;
        last_fall = cyc;
        step(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit((~^b) ^ bad_par, glitch);
        send_bit(1'b1, glitch);
        ps2_data = 1'b1;
        step(2 * H);
    endtask

    initial begin
        step(5);
        check("reset_key", 32'(ps2_key), 32'h000);
        check("reset_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        step(2 * H);

        send_frame(8'h1C, 1'b0, 1'b0);
        check("a_press", 32'(ps2_key), 32'h61C);
        check("stop_to_key_latency", 32'(key_chg_cyc - last_fall), 32'd11);

        send_frame(8'hF0, 1'b0, 1'b0);
        check("f0_no_output", 32'(ps2_key), 32'h61C);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("a_release", 32'(ps2_key), 32'h01C);

        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("ext_press", 32'(ps2_key), 32'h775);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("ext_release", 32'(ps2_key), 32'h175);
        check("no_err_good_frames", 32'(err_cnt), 32'd0);

        // Single clock pulse with data high: bad start bit.
        ps2_data = 1'b1;
        step(H);
        ps2_clk = 1'b0;
        step(H);
        ps2_clk = 1'b1;
        step(2 * H);
        check("start_err", 32'(err_cnt), 32'd1);
        check("start_err_key", 32'(ps2_key), 32'h175);

        send_frame(8'h29, 1'b1, 1'b0);
        check("parity_err", 32'(err_cnt), 32'd2);
        check("parity_err_key", 32'(ps2_key), 32'h175);
        send_frame(8'h29, 1'b0, 1'b0);
        check("after_parity", 32'(ps2_key), 32'h629);

        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0);
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0);
        check("pause_swallowed", 32'(ps2_key), 32'h629);
        send_frame(8'h05, 1'b0, 1'b0);
        check("after_pause", 32'(ps2_key), 32'h205);

        send_frame(8'hAA, 1'b0, 1'b0);
        check("ctrl_ignored", 32'(ps2_key), 32'h205);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0);
        check("ctrl_with_rel", 32'(ps2_key), 32'h4AA);
        check("no_err_pause_ctrl", 32'(err_cnt), 32'd2);

        // Start bit plus three data bits, then the line goes idle.
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        step(TMO + 40);
        check("timeout_err", 32'(err_cnt), 32'd3);
        check("timeout_latency", 32'(err_cyc - last_fall), 32'(10 + TMO));
        check("timeout_key", 32'(ps2_key), 32'h4AA);
        send_frame(8'h14, 1'b0, 1'b0);
        check("after_timeout", 32'(ps2_key), 32'h214);

        send_frame(8'h1C, 1'b0, 1'b1);
        check("glitch_decode", 32'(ps2_key), 32'h61C);
        check("glitch_no_err", 32'(err_cnt), 32'd3);

        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        reset_n = 1'b0;
        step(3);
        check("midreset_key", 32'(ps2_key), 32'h000);
        check("midreset_err", 32'(frame_err), 32'h0);
        reset_n  = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        step(2 * H);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("after_reset", 32'(ps2_key), 32'h61C);
        check("midreset_no_err", 32'(err_cnt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
